// File: rtl/fan_reg_arbiter.sv
// Round-robin arbiter sharing the fan AXI4-Lite register slave
// between the CPU bridge (idx 0) and the thermal loop (idx 1).
module fan_reg_arbiter #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [63:0]           req_wdata,
    output logic [1:0]            req_done,
    output logic [31:0]           req_rdata,
    output logic [1:0]            req_resp,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int unsigned LIMIT = NUM_REGS * 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RD,
        RR,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [1:0]          resp_q, resp_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                sel_gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic [31:0]         addr_ext;
    logic                bad_addr;

    always_comb begin
        sel_gnt = (&req_valid) ? ~last_gnt_q : req_valid[1];
        sel_addr = sel_gnt ? req_addr[2*ADDR_W-1:ADDR_W]
                           : req_addr[ADDR_W-1:0];
        sel_wdata = sel_gnt ? req_wdata[63:32] : req_wdata[31:0];
        addr_ext = '0;
        addr_ext[ADDR_W-1:0] = sel_addr;
        bad_addr = (addr_ext >= LIMIT) || (sel_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        resp_d     = resp_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gnt_d      = sel_gnt;
                    last_gnt_d = sel_gnt;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    if (bad_addr) begin
                        // answered locally, the bus never sees it
                        resp_d  = 2'b11;
                        rdata_d = '0;
                        state_d = DONE;
                    end else if (req_we[sel_gnt]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WB;
            end
            WB: begin
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    state_d = DONE;
                end
            end
            RD: begin
                if (m_axi_arready) state_d = RR;
            end
            RR: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            resp_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        req_done = '0;
        if (state_q == DONE) req_done[gnt_q] = 1'b1;
    end

    assign req_rdata     = rdata_q;
    assign req_resp      = resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == WB);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == RD);
    assign m_axi_rready  = (state_q == RR);

endmodule

// File: tb/tb_fan_reg_arbiter.sv
// Directed bench for fan_reg_arbiter with a small AXI4-Lite slave model.
// Built with ADDR_W=5 so out-of-range addresses such as 0x10 are representable.
module tb_fan_reg_arbiter;

    localparam int AW = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [63:0]     req_wdata = '0;
    logic [1:0]      req_done;
    logic [31:0]     req_rdata;
    logic [1:0]      req_resp;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wvalid;
    logic            wready = 1'b0;
    logic [1:0]      bresp = '0;
    logic            bvalid = 1'b0;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready = 1'b0;
    logic [31:0]     rdata = '0;
    logic [1:0]      rresp = '0;
    logic            rvalid = 1'b0;
    logic            rready;

    always #5 clock = ~clock;

    fan_reg_arbiter #(.ADDR_W(AW), .NUM_REGS(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // slave model knobs and bookkeeping
    int            aw_delay = 0;
    int            w_delay = 0;
    logic          b_hold = 1'b0;
    logic [1:0]    bresp_val = 2'b00;
    int            aw_wait = 0, w_wait = 0;
    logic          have_aw = 0, have_w = 0, have_ar = 0;
    logic          b_clr = 0, r_clr = 0;
    logic [AW-1:0] pend_addr = '0, ar_addr = '0;
    logic [31:0]   pend_data = '0;
    logic [31:0]   mem [0:7];
    int            aw_beats = 0, w_beats = 0, b_beats = 0;
    int            ar_cycles = 0, aw_cycles = 0, done_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;

    always @(negedge clock) begin
        if (reset) begin
            awready = 0; wready = 0; arready = 0;
            bvalid = 0; rvalid = 0;
            have_aw = 0; have_w = 0; have_ar = 0;
            b_clr = 0; r_clr = 0; aw_wait = 0; w_wait = 0;
        end else begin
            if (b_clr) begin bvalid = 0; b_clr = 0; end
            if (!bvalid && have_aw && have_w && !b_hold) begin
                mem[pend_addr[4:2]] = pend_data;
                bresp = bresp_val;
                bvalid = 1;
                have_aw = 0;
                have_w = 0;
            end
            if (bvalid && bready) begin b_beats++; b_clr = 1; end
            if (r_clr) begin rvalid = 0; r_clr = 0; end
            if (!rvalid && have_ar) begin
                rdata = mem[ar_addr[4:2]];
                rresp = 2'b00;
                rvalid = 1;
                have_ar = 0;
            end
            if (rvalid && rready) r_clr = 1;
            if (awvalid) begin
                aw_cycles++;
                awready = (aw_wait >= aw_delay);
                aw_wait++;
            end else begin
                awready = 0;
                aw_wait = 0;
            end
            if (awvalid && awready) begin
                aw_beats++; pend_addr = awaddr; have_aw = 1;
            end
            if (wvalid) begin
                wready = (w_wait >= w_delay);
                w_wait++;
            end else begin
                wready = 0;
                w_wait = 0;
            end
            if (wvalid && wready) begin
                w_beats++; pend_data = wdata; have_w = 1;
            end
            if (arvalid) begin
                ar_cycles++;
                arready = 1;
                ar_addr = araddr;
                have_ar = 1;
            end else begin
                arready = 0;
            end
        end
        if (|req_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int idx, input logic we,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
        req_we[idx] = we;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*32 +: 32] = wd;
        req_valid[idx] = 1'b1;
    endtask

    // waits for the pulse, captures outputs in the DONE cycle, ends in IDLE
    task automatic wait_done(output logic [1:0] d, output logic [31:0] rd,
                             output logic [1:0] rs, output int cyc);
        d = '0; rd = '0; rs = '0; cyc = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (req_done != 2'b00) begin
                d = req_done; rd = req_rdata; rs = req_resp;
                break;
            end
        end
        chk("done_seen", {31'b0, |d}, 32'h1);
        req_valid = '0;
        tick();
    endtask

    task automatic xact(input int idx, input logic we,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        output logic [1:0] d, output logic [31:0] rd,
                        output logic [1:0] rs, output int cyc);
        issue(idx, we, addr, wd);
        wait_done(d, rd, rs, cyc);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    logic [1:0]  d;
    logic [31:0] rd;
    logic [1:0]  rs;
    int          cyc;
    int          base_aw, base_w, base_b, base_ar, base_done;
    int          order [8];
    int          k, cnt0, cnt1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'hDEAD_0000 + i;

        // reset state
        repeat (2) tick();
        chk("rst_done", {30'b0, req_done}, 32'h0);
        chk("rst_rdata", req_rdata, 32'h0);
        chk("rst_resp", {30'b0, req_resp}, 32'h0);
        chk("rst_valids", {28'b0, awvalid, wvalid, arvalid, 1'b0}, 32'h0);
        chk("rst_readies", {30'b0, bready, rready}, 32'h0);
        chk("wstrb", {28'b0, wstrb}, 32'hF);
        chk("prot", {26'b0, awprot, arprot}, 32'h0);
        reset = 1'b0;
        tick();

        // T1 single write
        base_aw = aw_beats; base_w = w_beats;
        xact(0, 1'b1, 5'h0, 32'h0000_0001, d, rd, rs, cyc);
        chk("t1_done", {30'b0, d}, 32'h1);
        chk("t1_resp", {30'b0, rs}, 32'h0);
        chk("t1_lat", cyc, 4);
        chk("t1_aw_beats", aw_beats - base_aw, 1);
        chk("t1_w_beats", w_beats - base_w, 1);
        chk("t1_mem", mem[0], 32'h0000_0001);

        // T4 write then read back 0x8
        xact(0, 1'b1, 5'h8, 32'h0000_0003, d, rd, rs, cyc);
        chk("t4_wr_resp", {30'b0, rs}, 32'h0);
        xact(0, 1'b0, 5'h8, 32'h0, d, rd, rs, cyc);
        chk("t4_done", {30'b0, d}, 32'h1);
        chk("t4_rdata", rd, 32'h0000_0003);
        chk("t4_resp", {30'b0, rs}, 32'h0);
        chk("t4_lat", cyc, 4);
        chk("t4_hold", req_rdata, 32'h0000_0003);

        // slave error passes through on the write response
        bresp_val = 2'b10;
        xact(1, 1'b1, 5'h4, 32'hCAFE_0004, d, rd, rs, cyc);
        chk("slverr_done", {30'b0, d}, 32'h2);
        chk("slverr_resp", {30'b0, rs}, 32'h2);
        bresp_val = 2'b00;

        // T3 wready three cycles ahead of awready
        aw_delay = 3; w_delay = 0;
        base_aw = aw_beats; base_w = w_beats;
        base_b = b_beats; base_done = done_cnt;
        issue(0, 1'b1, 5'hC, 32'h0000_00C3);
        tick();
        chk("t3_both_up", {30'b0, awvalid, wvalid}, 32'h3);
        tick();
        chk("t3_w_first", {30'b0, awvalid, wvalid}, 32'h2);
        tick();
        chk("t3_aw_held", {30'b0, awvalid, wvalid}, 32'h2);
        chk("t3_awaddr", {27'b0, awaddr}, 32'hC);
        wait_done(d, rd, rs, cyc);
        chk("t3_done", {30'b0, d}, 32'h1);
        chk("t3_b_once", b_beats - base_b, 1);
        chk("t3_aw_once", aw_beats - base_aw, 1);
        chk("t3_w_once", w_beats - base_w, 1);
        chk("t3_done_once", done_cnt - base_done, 1);
        chk("t3_mem", mem[3], 32'h0000_00C3);
        aw_delay = 0;

        // T5 out-of-range and misaligned
        base_aw = aw_cycles; base_ar = ar_cycles;
        xact(1, 1'b0, 5'h10, 32'h0, d, rd, rs, cyc);
        chk("t5_done", {30'b0, d}, 32'h2);
        chk("t5_resp", {30'b0, rs}, 32'h3);
        chk("t5_rdata", rd, 32'h0);
        chk("t5_lat", cyc, 2);
        xact(0, 1'b1, 5'h6, 32'h1234_5678, d, rd, rs, cyc);
        chk("misalign_resp", {30'b0, rs}, 32'h3);
        chk("t5_no_ar", ar_cycles - base_ar, 0);
        chk("t5_no_aw", aw_cycles - base_aw, 0);

        // T2 both requesters held, starting from last_gnt = 1
        do_reset();
        req_we = 2'b01;
        req_addr = {5'hC, 5'h0};
        req_wdata = {32'h0, 32'h0000_0011};
        req_valid = 2'b11;
        k = 0; cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 100 && k < 8; i++) begin
            tick();
            if (req_done != 2'b00) begin
                order[k] = int'(req_done[1]);
                k++;
                if (req_done[1]) cnt1++;
                else cnt0++;
                if (cnt0 == 4) req_valid[0] = 1'b0;
                if (cnt1 == 4) req_valid[1] = 1'b0;
            end
        end
        req_valid = '0;
        chk("t2_total", k, 8);
        for (int j = 0; j < k; j++)
            chk($sformatf("t2_order%0d", j), order[j], j % 2);
        tick();
        tick();

        // T6 reset while waiting for B
        b_hold = 1'b1;
        issue(0, 1'b1, 5'h4, 32'h0000_00A5);
        for (int i = 0; i < 20 && !bready; i++) tick();
        chk("t6_in_wb", {31'b0, bready}, 32'h1);
        base_done = done_cnt;
        reset = 1'b1;
        req_valid = '0;
        tick();
        chk("t6_bready", {31'b0, bready}, 32'h0);
        chk("t6_req_done", {30'b0, req_done}, 32'h0);
        chk("t6_resp", {30'b0, req_resp}, 32'h0);
        tick();
        reset = 1'b0;
        b_hold = 1'b0;
        tick();
        chk("t6_no_done", done_cnt - base_done, 0);
        xact(0, 1'b1, 5'h4, 32'h0000_005A, d, rd, rs, cyc);
        chk("t6_done", {30'b0, d}, 32'h1);
        chk("t6_wr_resp", {30'b0, rs}, 32'h0);
        chk("t6_lat", cyc, 4);
        xact(0, 1'b0, 5'h4, 32'h0, d, rd, rs, cyc);
        chk("t6_rdback", rd, 32'h0000_005A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
